// File: rtl/glyph_stream_reader_pkg.sv
// Shared display definitions: raster geometry, digit validity and reader FSM states.
package glyph_stream_reader_pkg;

  localparam int GLYPH_W = 32;
  localparam int GLYPH_H = 32;
  localparam int ADDR_W  = 10;
  localparam int X_W     = 6;
  localparam int Y_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_FIN
  } state_t;

  // Only decimal digit codes have glyphs in the ROM bank.
  function automatic logic digit_ok(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/glyph_stream_reader_raster_counter.sv
// Raster position for the two-glyph image: x/y counters with wrap,
// last-pixel detection and the glyph-local ROM address.
module glyph_raster_counter #(
  parameter int GLYPH_W = 32,
  parameter int GLYPH_H = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       step_i,
  output logic [5:0] x_o,
  output logic [4:0] y_o,
  output logic       last_o,
  output logic [9:0] addr_o
);
  import glyph_stream_reader_pkg::*;

  // The image is two glyphs wide.
  localparam logic [X_W-1:0] X_MAX = X_W'(2 * GLYPH_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GLYPH_H - 1);

  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;

  // Advance one pixel per step; x wrap carries into y, y wraps after the last row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clear_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (step_i) begin
      if (x_q == X_MAX) begin
        x_q <= '0;
        y_q <= (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == X_MAX) && (y_q == Y_MAX);
  // Both glyphs share the same address space; the column folds modulo GLYPH_W.
  assign addr_o = ADDR_W'(y_q) * ADDR_W'(GLYPH_W) + ADDR_W'(x_q & X_W'(GLYPH_W - 1));

endmodule

// File: rtl/glyph_stream_reader.sv
// Reads two digit glyphs from the ROM bank pixel by pixel and streams them
// as one side-by-side raster image over a valid/ready interface.
module glyph_stream_reader #(
  parameter int         GLYPH_W  = 32,
  parameter int         GLYPH_H  = 32,
  parameter int         READ_LAT = 2,
  parameter logic [7:0] BLANK    = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] digit_a,
  input  logic [3:0] digit_b,
  output logic       busy,
  output logic       done,
  output logic       ena_a,
  output logic       ena_b,
  output logic [3:0] result_1,
  output logic [3:0] result_2,
  output logic [9:0] address,
  input  logic [7:0] r_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [7:0] pix_data,
  output logic [5:0] pix_x,
  output logic [4:0] pix_y,
  output logic       pix_last
);
  import glyph_stream_reader_pkg::*;

  state_t     state_q;
  logic       busy_q, done_q, pix_valid_q, pix_last_q;
  logic [7:0] pix_data_q;
  logic [3:0] res1_q, res2_q;
  logic [2:0] wait_q;

  logic [5:0] x_w;
  logic [4:0] y_w;
  logic       last_w;
  logic [9:0] addr_w;
  logic       side_b, sel_ok, reading;
  logic [3:0] sel_code;

  glyph_raster_counter #(
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q == S_IDLE && start),
    .step_i  (state_q == S_OUT && pix_ready),
    .x_o     (x_w),
    .y_o     (y_w),
    .last_o  (last_w),
    .addr_o  (addr_w)
  );

  // Right half of the image belongs to the second digit.
  assign side_b   = (x_w >= 6'(GLYPH_W));
  assign sel_code = side_b ? res2_q : res1_q;
  assign sel_ok   = digit_ok(sel_code);
  // Enables stay up through the whole read so the bank's output mux stays on the right glyph.
  assign reading  = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign ena_a    = reading && sel_ok && !side_b;
  assign ena_b    = reading && sel_ok && side_b;

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_1  = res1_q;
  assign result_2  = res2_q;
  assign address   = addr_w;
  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_x     = x_w;
  assign pix_y     = y_w;
  assign pix_last  = pix_last_q;

  // Reader FSM: issue a read (or skip it for blank digits), wait out the ROM latency,
  // then hold the pixel until the compositor accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      pix_data_q  <= '0;
      res1_q      <= '0;
      res2_q      <= '0;
      wait_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            res1_q  <= digit_a;
            res2_q  <= digit_b;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!sel_ok) begin
            pix_data_q  <= BLANK;
            pix_valid_q <= 1'b1;
            pix_last_q  <= last_w;
            state_q     <= S_OUT;
          end else if (READ_LAT == 1) begin
            pix_data_q  <= r_data;
            pix_valid_q <= 1'b1;
            pix_last_q  <= last_w;
            state_q     <= S_OUT;
          end else begin
            wait_q  <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_q == 3'(READ_LAT - 2)) begin
            pix_data_q  <= r_data;
            pix_valid_q <= 1'b1;
            pix_last_q  <= last_w;
            state_q     <= S_OUT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_OUT: begin
          if (pix_ready) begin
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            if (last_w) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FIN;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_stream_reader.sv
// Directed bench for glyph_stream_reader with a one-stage registered ROM model.
module tb_glyph_stream_reader;

  logic       clk = 1'b0;
  logic       rst, start, pix_ready;
  logic [3:0] digit_a, digit_b;
  logic       busy, done, ena_a, ena_b, pix_valid, pix_last;
  logic [3:0] result_1, result_2;
  logic [9:0] address;
  logic [7:0] r_data = 8'h00;
  logic [7:0] pix_data;
  logic [5:0] pix_x;
  logic [4:0] pix_y;

  int total = 0;
  int bad = 0;
  int done_total = 0;

  glyph_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .digit_a   (digit_a),
    .digit_b   (digit_b),
    .busy      (busy),
    .done      (done),
    .ena_a     (ena_a),
    .ena_b     (ena_b),
    .result_1  (result_1),
    .result_2  (result_2),
    .address   (address),
    .r_data    (r_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last)
  );

  always #5 clk = ~clk;

  // ROM bank: pixel = low address byte, one registered stage; 8'hEE if nothing is selected.
  always @(posedge clk) r_data <= (ena_a || ena_b) ? address[7:0] : 8'hEE;

  always @(posedge clk) if (done === 1'b1) done_total++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({busy, done, ena_a, ena_b, pix_valid, pix_last, pix_data, pix_x, pix_y,
                    address, result_1, result_2}), 64'(0));
  endtask

  // Renders one frame and checks every pixel, enable behaviour and the done handshake.
  task automatic run_frame(input logic [3:0] da, input logic [3:0] db, input bit stall, input bit poke);
    int n, cyc, ncnt, lat, addr_err, both, res_err, hold_err, ex, ey, ea, exp_cyc;
    bit vd, held;
    logic [7:0] held_data, edata;
    logic [1:0] side, eside;
    n = 0; cyc = 0; ncnt = 0; addr_err = 0; both = 0; res_err = 0; hold_err = 0;
    held = 0; held_data = 8'h00; side = 2'd0;
    exp_cyc = 1 + 1024 * ((da <= 4'd9) ? 3 : 2) + 1024 * ((db <= 4'd9) ? 3 : 2);
    pix_ready = 1'b1;
    start = 1'b1; digit_a = da; digit_b = db;
    @(negedge clk); ncnt++;
    start = 1'b0; digit_a = 4'd5; digit_b = 4'd6;
    check("issue_busy", 64'(busy), 64'(1));
    check("issue_addr", 64'(address), 64'(0));
    check("issue_ena_a", 64'(ena_a), 64'(da <= 4'd9));
    lat = 1;
    while (!pix_valid && lat < 10) begin
      if (ena_a) side = 2'd1;
      if (ena_b) side = 2'd2;
      @(negedge clk); ncnt++; lat++;
    end
    check("first_latency", 64'(lat), (da <= 4'd9) ? 64'(3) : 64'(2));
    while (n < 2048 && cyc < 30000) begin
      ex = n % 64; ey = n / 64; ea = ey * 32 + (ex % 32);
      if (ena_a && ena_b) both++;
      if (ena_a || ena_b) begin
        if (address !== 10'(ea)) addr_err++;
      end
      if (ena_a) side = 2'd1;
      if (ena_b) side = 2'd2;
      if (result_1 !== da || result_2 !== db) res_err++;
      if (held && pix_data !== held_data) hold_err++;
      start = poke && (cyc % 401 == 37);
      pix_ready = stall ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (pix_valid && pix_ready) begin
        vd    = (ex < 32) ? (da <= 4'd9) : (db <= 4'd9);
        edata = vd ? 8'(ea) : 8'h00;
        eside = vd ? ((ex < 32) ? 2'd1 : 2'd2) : 2'd0;
        check("pixel", 64'({side, pix_last, pix_x, pix_y, pix_data}),
              64'({eside, (n == 2047), 6'(ex), 5'(ey), edata}));
        side = 2'd0; held = 0; n++;
      end else begin
        held = pix_valid; held_data = pix_data;
      end
      @(negedge clk); ncnt++; cyc++;
    end
    start = 1'b0;
    check("frame_pixels", 64'(n), 64'(2048));
    check("fin_done_busy_valid", 64'({done, busy, pix_valid}), 64'(3'b100));
    if (!stall) check("frame_cycles", 64'(ncnt), 64'(exp_cyc));
    // A start during the FIN cycle must be ignored.
    start = poke; digit_a = 4'd5; digit_b = 4'd6;
    @(negedge clk);
    start = 1'b0;
    check("idle_after_fin", 64'({done, busy, result_1, result_2}), 64'({1'b0, 1'b0, da, db}));
    check("enable_overlap", 64'(both), 64'(0));
    check("address_err", 64'(addr_err), 64'(0));
    check("result_stable", 64'(res_err), 64'(0));
    check("stall_hold", 64'(hold_err), 64'(0));
    $display("frame a=%0d b=%0d stall=%0d poke=%0d pixels=%0d cycles=%0d", da, db, stall, poke, n, ncnt);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; digit_a = 4'd0; digit_b = 4'd0; pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    run_frame(4'd3, 4'd7, 1'b0, 1'b1);
    run_frame(4'd3, 4'd7, 1'b1, 1'b0);
    run_frame(4'd12, 4'd1, 1'b0, 1'b0);

    // Reset while a pixel sits in OUT at (10,5).
    pix_ready = 1'b1;
    start = 1'b1; digit_a = 4'd3; digit_b = 4'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(pix_valid && pix_x == 6'd10 && pix_y == 5'd5) && cyc < 20000) begin
      @(negedge clk); cyc++;
    end
    check("reach_10_5", 64'({pix_valid, pix_x, pix_y}), 64'({1'b1, 6'd10, 5'd5}));
    pix_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("midframe_reset");
    @(negedge clk);
    rst = 1'b0;
    $display("reset mid-frame at (10,5) after %0d cycles", cyc);

    run_frame(4'd9, 4'd10, 1'b0, 1'b1);
    run_frame(4'd15, 4'd0, 1'b1, 1'b0);

    check("done_count", 64'(done_total), 64'(5));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/glyph_stream_reader.md
# glyph_stream_reader

Raster reader that sits directly upstream of the two-digit glyph ROM bank and drives its select, digit and address inputs. It reads back 8-bit glyph pixels and emits them as a valid/ready pixel stream toward the display compositor. Each start command renders the two recognised digits side by side as one 64×32 image in row-major raster order. Digits above 9 render as blank pixels without a ROM read.

## Interface
Parameters:
- GLYPH_W, 32: glyph width in pixels; a power of two.
- GLYPH_H, 32: glyph height in rows; GLYPH_W×GLYPH_H = 1024 = ROM depth.
- READ_LAT, 2: cycles from address/enable presentation to valid r_data; 1..4.
- BLANK, 8'h00: pixel value emitted for an invalid digit.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle render request.
- digit_a  in  4  left digit code, sampled with start.
- digit_b  in  4  right digit code, sampled with start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last pixel transfers.
- ena_a  out  1  ROM select for the left digit.
- ena_b  out  1  ROM select for the right digit.
- result_1  out  4  left digit code to the ROM bank.
- result_2  out  4  right digit code to the ROM bank.
- address  out  10  glyph address = y*GLYPH_W + (x mod GLYPH_W).
- r_data  in  8  glyph pixel returned by the ROM bank.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  downstream accept.
- pix_data  out  8  pixel value.
- pix_x  out  6  column, 0..63.
- pix_y  out  5  row, 0..31.
- pix_last  out  1  high with pixel (63,31).

## Operation
FSM states: IDLE, ISSUE, WAIT, OUT, FIN.
- IDLE:
  - A start pulse latches digit_a and digit_b into result_1 and result_2, clears x and y to 0, and goes to ISSUE.
  - Start is ignored in every other state.
- ISSUE:
  - Drives address for the current (x, y).
  - Asserts ena_a if x<32, ena_b if x≥32; never both in the same cycle.
  - If the selected digit is above 9, both enables stay low and the state goes straight to OUT with pix_data=BLANK.
  - Otherwise goes to WAIT.
- WAIT:
  - Holds address, enable and result_* stable.
  - Counts READ_LAT-1 cycles, then captures r_data into pix_data and goes to OUT.
  - Holding the selection stable is mandatory, because the ROM bank's output mux depends on the enables during readback.
- OUT:
  - pix_valid=1; pix_data, pix_x, pix_y and pix_last are held until pix_valid&pix_ready.
  - On transfer: x increments; x wrapping from 63 to 0 increments y.
  - Transfer of (63,31) goes to FIN; any other transfer goes to ISSUE.
- FIN: done=1 for one cycle, busy drops, returns to IDLE.
- ena_a and ena_b are low in IDLE, OUT and FIN.
- result_1 and result_2 hold their latched values until the next accepted start.
- Reset at any point forces IDLE. Reset values:
  - busy, done, ena_a, ena_b, pix_valid, pix_last = 0.
  - pix_data, pix_x, pix_y, address, result_1, result_2 = 0.
- A start arriving in the same cycle as the FIN→IDLE transition is ignored.

## Timing
- start in cycle t → busy=1 and the ISSUE state at t+1 (address 0, ena_a=1).
- Valid digit: capture at the end of cycle t+1+READ_LAT-1; pix_valid=1 from t+1+READ_LAT.
- Invalid digit: pix_valid=1 at t+2.
- Per pixel with pix_ready held high: READ_LAT+1 cycles for a valid digit, 2 cycles for a blank.
- Full frame with ready always high and READ_LAT=2: 2048×3 cycles + start + FIN.
- pix_ready low stalls indefinitely in OUT; no pixel is lost or duplicated.
- done asserts the cycle after the final handshake; busy falls in the same cycle as done.

## Structure
- The shared display package holds:
  - GLYPH_W, GLYPH_H and the derived ADDR_W=10, X_W=6, Y_W=5.
  - The digit-valid function (code ≤ 9).
  - The FSM state enum.
- One natural sub-module, glyph_raster_counter: the x/y counter with wrap and last detection, plus address generation.
- The FSM and the read-latency counter live in glyph_stream_reader.

## Test plan
- Reset mid-frame:
  - Stimulus: assert rst while in OUT at (10,5).
  - Required response: all outputs go to 0 immediately; a new start renders from (0,0).
- Digits 3 and 7, pix_ready=1, ROM model returning address[7:0]:
  - 2048 pixels arrive in raster order.
  - pix_data at (40,2) = 8'h48, from ena_b and address 72.
  - pix_last only at (63,31); done one cycle later.
- Enable exclusivity:
  - Over a full frame, ena_a and ena_b are never high together.
  - result_1=3 and result_2=7 stay constant throughout.
- Backpressure:
  - Stimulus: random pix_ready at 30% duty.
  - Required response: pixel sequence and values identical to the unstalled run; pix_data stable while valid&!ready.
- Invalid digit:
  - Stimulus: digit_a=4'd12, digit_b=4'd1.
  - Required response: x<32 pixels = 8'h00 with ena_a never asserted; x≥32 pixels read from the ROM bank.
- start pulses while busy=1:
  - Required response: ignored; result_1 and result_2 unchanged; exactly one done per accepted start.
